// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake bundle for pipe_stage_reg; stall_cnt present with PIPE_STALL_CNT_EN
interface pipe_stage_reg_if #(
  parameter int DATA_W = 139
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0]       stall_cnt;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );
`else
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready stage register with 2-entry skid; PIPE_STALL_CNT_EN adds stall_cnt
module pipe_stage_reg #(
  parameter int              DATA_W    = 139,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stage_reg_if.slave bus
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Handshake outputs are flopped alongside the state so no ready path crosses the stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
    end else if (bus.flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q      <= bus.in_data;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= bus.in_data;
          end else if (in_fire) begin
            skid_q     <= bus.in_data;
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating; survives flush so stalls across recovery are still counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 32'd0;
    end else if (out_valid_q && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - vector table plus scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int DW = 8;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          ov;
    logic          ir;
    logic [1:0]    occ;
    logic [DW-1:0] od;
    logic          chk_od;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [DW-1:0] sbq[$];
  vec_t tv[12];

  pipe_stage_reg_if #(.DATA_W(DW)) bus ();

  pipe_stage_reg #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected payloads queued when accepted, compared when the DUT delivers.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          chk("sb_out", 32'(bus.out_data), 32'(sbq.pop_front()));
        end
      end
      if (bus.flush) sbq.delete();
      else if (bus.in_valid && bus.in_ready) sbq.push_back(bus.in_data);
    end
  end

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tv[i].iv, tv[i].d, tv[i].ordy, tv[i].fl);
      step();
      chk($sformatf("row%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].ov));
      chk($sformatf("row%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].ir));
      chk($sformatf("row%0d_occupancy", i), 32'(bus.occupancy), 32'(tv[i].occ));
      if (tv[i].chk_od) chk($sformatf("row%0d_out_data", i), 32'(bus.out_data), 32'(tv[i].od));
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(ir));
    chk({tag, "_occupancy"}, 32'(bus.occupancy), 32'(occ));
  endtask

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall0;
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //             iv    d      ordy  fl    ov    ir    occ    od     chk
    tv[0]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h01, 1'b1};
    tv[1]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h02, 1'b1};
    tv[2]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h03, 1'b1};
    tv[3]  = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h04, 1'b1};
    tv[4]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'h05, 1'b1};
    tv[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0};
    tv[6]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA1, 1'b1};
    tv[7]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1, 1'b1};
    tv[8]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 8'hA1, 1'b1};
    tv[9]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA2, 1'b1};
    tv[10] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 8'hA3, 1'b1};
    tv[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0};

    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    chk_state("reset", 1'b0, 1'b1, 2'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'h0);
`ifdef PIPE_STALL_CNT_EN
    chk("reset_stall_cnt", bus.stall_cnt, 32'd0);
`endif
    rst = 1'b1;

    run_rows(0, 8);

    // Held at FULL: output must not move while downstream stalls.
`ifdef PIPE_STALL_CNT_EN
    stall0 = bus.stall_cnt;
`endif
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'hA3, 1'b0, 1'b0);
      step();
      chk($sformatf("hold%0d_out_data", k), 32'(bus.out_data), 32'hA1);
      chk($sformatf("hold%0d_out_valid", k), 32'(bus.out_valid), 32'h1);
    end
`ifdef PIPE_STALL_CNT_EN
    chk("stall_cnt_delta", bus.stall_cnt - stall0, 32'd10);
`endif

    run_rows(9, 11);

    // Flush while FULL with a payload offered in the same cycle.
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    step();
    chk_state("fill_b", 1'b1, 1'b0, 2'd2);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    step();
    chk_state("flush_full", 1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 8'h77, 1'b1, 1'b0);
      step();
      chk_state($sformatf("post_flush%0d", k), 1'b0, 1'b1, 2'd0);
    end

    // Flush coinciding with an out_fire: the delivered payload still counts.
    drive(1'b1, 8'hC1, 1'b1, 1'b0);
    step();
    chk("c1_out_data", 32'(bus.out_data), 32'hC1);
    drive(1'b1, 8'hC2, 1'b1, 1'b1);
    step();
    chk_state("flush_one", 1'b0, 1'b1, 2'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk_state("after_c", 1'b0, 1'b1, 2'd0);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'hD2, 1'b0, 1'b0);
    step();
    chk_state("fill_d", 1'b1, 1'b0, 2'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 1'b1, 2'd0);
    chk("async_rst_out_data", 32'(bus.out_data), 32'h0);
`ifdef PIPE_STALL_CNT_EN
    chk("async_rst_stall_cnt", bus.stall_cnt, 32'd0);
`endif
    #1 rst = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    step();
    chk_state("push_5a", 1'b1, 1'b1, 2'd1);
    chk("push_5a_out_data", 32'(bus.out_data), 32'h5A);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk_state("final_idle", 1'b0, 1'b1, 2'd0);
    step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed-field, hold-enabled stage registers between core pipeline stages (e.g. EX→MEM). The bundled payload is a single `DATA_W` vector. `in_ready` is driven from a flop, so backpressure never forms a combinational path through the stage. A synchronous flush kills in-flight contents for branch or trap recovery.

## Interface
Parameters:
- `DATA_W`, default 139: payload width. The EX→MEM bundle is funct3(3) + rd(5) + wb/rmem/wmem(3) + alu(64) + wdata(64).
- `RESET_VAL`, default `{DATA_W{1'b0}}`: reset value of both payload registers.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous kill of all stage contents.
- `in_valid`, input, 1: upstream payload valid.
- `in_ready`, output, 1: stage can accept; registered.
- `in_data`, input, `DATA_W`: upstream payload.
- `out_valid`, output, 1: `out_data` valid.
- `out_ready`, input, 1: downstream accepts.
- `out_data`, output, `DATA_W`: payload; driven directly from the main register.
- `occupancy`, output, 2: entries held (0, 1 or 2).
- `stall_cnt`, output, 32: backpressure cycle count. Present only with `PIPE_STALL_CNT_EN`.

## Operation
- Fires: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main register (drives `out_data`) and skid register.
- States: EMPTY (occupancy 0), ONE (1), FULL (2).
- Outputs by state: `out_valid = (state != EMPTY)`; `in_ready = (state != FULL)`, registered with the state.
- EMPTY: `in_fire` → main ← `in_data`, go to ONE.
- ONE, both fires → main ← `in_data`, stay in ONE.
- ONE, `in_fire` only → skid ← `in_data`, go to FULL.
- ONE, `out_fire` only → go to EMPTY.
- FULL: `in_ready = 0`, so no input is accepted. `out_fire` → main ← skid, go to ONE.
- No fire in any state → hold state and both registers.
- Flush has highest priority: next state is EMPTY whatever the fires.
  - A payload presented with `in_fire` in the flush cycle is dropped.
  - An `out_fire` in the flush cycle still counts as delivered downstream.
  - Payload registers are not cleared by flush; their contents are don't-care while `out_valid = 0`.
- Ordering: strict FIFO; no payload is duplicated or lost except by flush.
- Output stability: while `out_valid & ~out_ready`, `out_data` must not change except by flush or reset.
- Input sampling: `in_data` is sampled only on `in_fire`; upstream may change it freely otherwise.

## Timing
- Reset (`rst` low, asynchronous):
  - state = EMPTY, `out_valid = 0`, `in_ready = 1`, `occupancy = 0`
  - main = skid = `RESET_VAL`, `stall_cnt = 0`
- Reset release mid-transfer: all held payloads are lost. The first edge after release behaves as EMPTY.
- Latency: 1 cycle. A payload accepted at edge N is on `out_data` with `out_valid = 1` after edge N.
- Throughput: 1 payload per cycle when `out_ready` is held high; the stage stays in ONE.
- Backpressure: after one cycle of `out_ready = 0` with continuous input, the stage goes to FULL and `in_ready` drops after that edge. This two-entry depth covers the one-cycle registered-ready lag.
- Recovery: `in_ready` returns to 1 one edge after the first `out_fire` in FULL.

## Configuration
- `PIPE_STALL_CNT_EN` defined:
  - `stall_cnt` increments on each edge where `out_valid & ~out_ready`.
  - It saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset; flush does not clear it.
- Not defined: the port, counter and logic are absent. Handshake behaviour is identical either way.

## Test plan
- Reset then stream: `DATA_W = 8`, reset low then high, `out_ready = 1`, push 0x01..0x05 on consecutive cycles → `out_data` shows 0x01..0x05 one cycle later each, `in_ready` stays 1, occupancy stays ≤ 1.
- Backpressure fill/drain: push 0xA1, 0xA2, 0xA3 with `out_ready = 0` → occupancy 2, `in_ready = 0`, 0xA3 held off upstream. Raise `out_ready` → outputs 0xA1, 0xA2, 0xA3 in order, none lost.
- Output stability: hold `out_ready = 0` for 10 cycles at FULL → `out_data` stays 0xA1 and `out_valid` stays 1 throughout. With the macro defined, `stall_cnt` = 10.
- Flush during FULL with a simultaneous `in_valid` of 0x77 → next cycle `out_valid = 0`, occupancy 0, `in_ready = 1`; 0x77 never appears on the output.
- Async reset mid-stream: assert `rst` low between edges while FULL → `out_valid` falls to 0 immediately, `out_data = RESET_VAL`; after release a push of 0x5A emerges 1 cycle later.
